// File: rtl/mul32u_seq_pkg.sv
// Shared types and constants for the sequential 32x32 unsigned multiplier.
package mul32u_seq_pkg;

  localparam int unsigned OP_W     = 32;
  localparam int unsigned PROD_W   = 64;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned MUL_ITER = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul32u_seq_if.sv
// Start/busy/done handshake and operand/product bus of the sequential multiplier.
interface mul32u_seq_if;
  import mul32u_seq_pkg::*;

  logic              start;
  logic [OP_W-1:0]   mcand;
  logic [OP_W-1:0]   mplier;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] prod;

  modport master (output start, mcand, mplier, input busy, done, prod);
  modport slave  (input start, mcand, mplier, output busy, done, prod);

endinterface

// File: rtl/mul32u_seq_add32u.sv
// Combinational 32-bit unsigned adder; carry lands in sum[32].
module mul32u_seq_add32u
  import mul32u_seq_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul32u_seq.sv
// Sequential 32x32 unsigned shift-add multiplier: one partial product per cycle,
// 32 iterations, product held in an output register until the next completion.
module mul32u_seq
  import mul32u_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mul32u_seq_if.slave bus
);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W:0]   p_q, p_d;
  logic [OP_W-1:0]   m_q, m_d;
  logic [OP_W-1:0]   addend;
  logic [OP_W:0]     sum;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              unused_p_msb;

  // P[64] is architecturally always zero; kept only for register width.
  assign unused_p_msb = p_q[PROD_W];

  assign addend = p_q[0] ? m_q : '0;

  mul32u_seq_add32u u_add (
    .a   (p_q[PROD_W-1:OP_W]),
    .b   (addend),
    .sum (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    prod_d  = prod_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      MUL_RUN: begin
        p_d    = {1'b0, sum, p_q[OP_W-1:1]};
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
          state_d = MUL_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          prod_d  = p_d[PROD_W-1:0];
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation
        if (bus.start) begin
          state_d = MUL_RUN;
          busy_d  = 1'b1;
          m_d     = bus.mcand;
          p_d     = {{(PROD_W + 1 - OP_W){1'b0}}, bus.mplier};
          cnt_d   = '0;
        end else if (state_q == MUL_DONE) begin
          state_d = MUL_IDLE;
        end
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.prod = prod_q;

endmodule

// File: tb/tb_mul32u_seq.sv
// Self-checking bench for mul32u_seq: cycle-level reference model plus directed
// vectors with hand-computed products.
module tb_mul32u_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc_now = 0;

  mul32u_seq_if bus ();

  mul32u_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: an accepted start yields the arithmetic product 32 edges later.
  logic        m_busy, m_done;
  logic [63:0] m_prod, m_pend;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_pend <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_prod <= m_pend;
        end
        m_left <= m_left - 1;
      end else if (bus.start) begin
        m_busy <= 1'b1;
        m_left <= 32;
        m_pend <= 64'(bus.mcand) * 64'(bus.mplier);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
      chk("cyc_done", 64'(bus.done), 64'(m_done));
      chk("cyc_prod", bus.prod, m_prod);
      chk("busy_and_done", 64'(bus.busy & bus.done), 64'd0);
    end
  end

  task automatic wait_done(input int max, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
    int cyc;
    bit ok;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    @(posedge clk);
    #1;
    chk({name, "_busy_at_accept"}, 64'(bus.busy), 64'd1);
    bus.start  = 1'b0;
    bus.mcand  = $urandom;
    bus.mplier = $urandom;
    wait_done(40, cyc, ok);
    chk({name, "_done_seen"}, 64'(ok), 64'd1);
    chk({name, "_latency"}, 64'(cyc), 64'd32);
    chk({name, "_prod"}, bus.prod, exp);
  endtask

  initial begin
    int cyc;
    bit ok;
    int last_done;
    logic [31:0] a, b;

    bus.start  = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_prod", bus.prod, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "basic");
    chk("model_basic", m_prod, 64'h0000_0000_0000_000F);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
    chk("model_max", m_prod, 64'hFFFF_FFFE_0000_0001);
    run_op(32'd0, 32'h1234_5678, 64'd0, "zero_a");
    run_op(32'h8000_0000, 32'd0, 64'd0, "zero_b");
    run_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "carry32");

    // Start held through RUN: second operands are only taken in the DONE cycle.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 32'd7;
    bus.mplier = 32'd9;
    @(posedge clk);
    #1;
    bus.mcand  = 32'd2;
    bus.mplier = 32'd2;
    wait_done(40, cyc, ok);
    chk("ign_done_seen", 64'(ok), 64'd1);
    chk("ign_latency", 64'(cyc), 64'd32);
    chk("ign_first_prod", bus.prod, 64'd63);
    @(posedge clk);
    #1;
    chk("ign_second_accept", 64'(bus.busy), 64'd1);
    chk("ign_prod_held", bus.prod, 64'd63);
    bus.start = 1'b0;
    wait_done(40, cyc, ok);
    chk("ign_second_latency", 64'(cyc), 64'd32);
    chk("ign_second_prod", bus.prod, 64'd4);

    // Back-to-back: each start lands in the preceding DONE cycle.
    last_done = cyc_now;
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(a, b, 64'(a) * 64'(b), "b2b");
      chk("b2b_period", 64'(cyc_now - last_done), 64'd33);
      last_done = cyc_now;
    end

    // Reset mid-operation aborts immediately.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 32'hDEAD_BEEF;
    bus.mplier = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_done", 64'(bus.done), 64'd0);
    chk("rst_mid_prod", bus.prod, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd6, 32'd7, 64'd42, "post_rst");
    chk("model_post_rst", m_prod, 64'd42);

    repeat (3) @(posedge clk);
    #1;
    chk("idle_prod_held", bus.prod, 64'd42);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
